image_mem_scheduler: RTL

Sequences and shares the single-port 784-word MNIST image memory between three users: the keyboard drawing grid (single-word writes), the VGA refresh path (single-word reads), and the neural-network input loader (full-image streaming read). It also provides a hardware clear that zeroes the whole image. It sits between those requesters and the `image_memory` instance, and owns every memory port signal.

---
 rtl/image_mem_scheduler_if.sv | 49 ++++
 rtl/image_mem_scheduler.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/image_mem_scheduler_if.sv
// Request/ack and memory-port bundle between the image memory scheduler and its users.
// Handshake: a requester raises req with addr/data and holds them stable until it sees ack
// high for one cycle; ack means the access was placed on the memory port at that same edge,
// and for reads disp_valid/disp_data follow exactly one cycle after ack.
interface image_mem_scheduler_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              clear_start;
  logic              inf_start;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_ack;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              inf_valid;
  logic [ADDR_W-1:0] inf_index;
  logic [DATA_W-1:0] inf_data;
  logic              inf_done;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  clear_start, inf_start,
    input  wr_req, wr_addr, wr_data,
    input  disp_req, disp_addr,
    input  mem_rdata,
    output wr_ack, disp_ack, disp_valid, disp_data,
    output inf_valid, inf_index, inf_data, inf_done, busy,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output clear_start, inf_start,
    output wr_req, wr_addr, wr_data,
    output disp_req, disp_addr,
    output mem_rdata,
    input  wr_ack, disp_ack, disp_valid, disp_data,
    input  inf_valid, inf_index, inf_data, inf_done, busy,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/image_mem_scheduler.sv
// Shares the single-port MNIST image memory between draw writes, display reads,
// full-image inference streaming and a hardware clear; owns every memory port signal.
module image_mem_scheduler #(
  parameter int GRID_SIZE = 28,
  parameter int DEPTH     = GRID_SIZE * GRID_SIZE,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  image_mem_scheduler_if.slave  bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_DISP = 2'd1,
    SRC_STRM = 2'd2
  } src_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  src_t              src_q, src_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              wr_ack_q, wr_ack_d;
  logic              disp_ack_q, disp_ack_d;
  logic              clear_pend_q, clear_pend_d;
  logic              inf_pend_q, inf_pend_d;
  logic              disp_valid_q, inf_valid_q, inf_done_q;
  logic [ADDR_W-1:0] inf_index_q;
  logic              cnt_last;

  assign cnt_last = (cnt_q == LAST_ADDR);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // A start pulse arriving in the same cycle its flag is consumed re-arms the flag.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clear_pend_d = clear_pend_q | bus.clear_start;
    inf_pend_d   = inf_pend_q | bus.inf_start;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    wr_ack_d     = 1'b0;
    disp_ack_d   = 1'b0;
    src_d        = SRC_NONE;
    idx_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_pend_q) begin
          state_d      = ST_CLEAR;
          cnt_d        = '0;
          clear_pend_d = bus.clear_start;
        end else if (inf_pend_q) begin
          state_d    = ST_STREAM;
          cnt_d      = '0;
          inf_pend_d = bus.inf_start;
        end else if (bus.wr_req && !wr_ack_q) begin
          mem_addr_d  = bus.wr_addr;
          mem_wdata_d = bus.wr_data;
          mem_we_d    = 1'b1;
          wr_ack_d    = 1'b1;
        end else if (bus.disp_req && !disp_ack_q) begin
          mem_addr_d = bus.disp_addr;
          disp_ack_d = 1'b1;
          src_d      = SRC_DISP;
        end
      end
      ST_CLEAR: begin
        mem_addr_d  = cnt_q;
        mem_wdata_d = '0;
        mem_we_d    = 1'b1;
        if (cnt_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STREAM: begin
        mem_addr_d = cnt_q;
        src_d      = SRC_STRM;
        idx_d      = cnt_q;
        if (cnt_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // src_q tags which requester owns the read data arriving next cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      clear_pend_q <= 1'b0;
      inf_pend_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      wr_ack_q     <= 1'b0;
      disp_ack_q   <= 1'b0;
      src_q        <= SRC_NONE;
      idx_q        <= '0;
      disp_valid_q <= 1'b0;
      inf_valid_q  <= 1'b0;
      inf_index_q  <= '0;
      inf_done_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      clear_pend_q <= clear_pend_d;
      inf_pend_q   <= inf_pend_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      wr_ack_q     <= wr_ack_d;
      disp_ack_q   <= disp_ack_d;
      src_q        <= src_d;
      idx_q        <= idx_d;
      disp_valid_q <= (src_q == SRC_DISP);
      inf_valid_q  <= (src_q == SRC_STRM);
      inf_index_q  <= (src_q == SRC_STRM) ? idx_q : '0;
      inf_done_q   <= (src_q == SRC_STRM) && (idx_q == LAST_ADDR);
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.disp_ack   = disp_ack_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_data  = disp_valid_q ? bus.mem_rdata : '0;
  assign bus.inf_valid  = inf_valid_q;
  assign bus.inf_index  = inf_index_q;
  assign bus.inf_data   = inf_valid_q ? bus.mem_rdata : '0;
  assign bus.inf_done   = inf_done_q;
  // busy also covers the stream reads still in flight so it drops only after inf_done.
  assign bus.busy       = clear_pend_q | inf_pend_q | (state_q != ST_IDLE) |
                          (src_q == SRC_STRM) | inf_valid_q;
  assign dbg_state      = state_q;

endmodule
